// File: rtl/aes_byte_if.sv
// Byte-serial wrapper around the AES-128 round engine: gathers key/plaintext bytes,
// runs the engine under a watchdog, and streams the 16 cipher bytes back out.
module aes_byte_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic [127:0] eng_plain,
  output logic [127:0] eng_key,
  output logic         eng_start,
  input  logic [127:0] eng_cipher,
  input  logic         eng_ok,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_PT,
    RUN,
    DRAIN
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic [3:0]    byte_cnt;
  logic [15:0]   wdog;
  logic [127:0]  shift;
  logic          in_fire;
  logic          out_fire;
  logic          timeout_hit;
  logic          load_key_byte;
  logic          load_pt_byte;
  logic [6:0]    byte_msb;

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign timeout_hit = (wdog == WDOG_LAST);
  assign out_data    = shift[127:120];
  // Byte i lands at bit 127-8i, i.e. {~i, 3'b111}
  assign byte_msb    = {~byte_cnt, 3'b111};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    load_key_byte = 1'b0;
    load_pt_byte  = 1'b0;
    out_valid     = 1'b0;
    eng_start     = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (in_fire) begin
          if (in_keep_key) begin
            load_pt_byte = 1'b1;
            next_state   = LOAD_PT;
          end else begin
            load_key_byte = 1'b1;
            next_state    = LOAD_KEY;
          end
        end
      end
      LOAD_KEY: begin
        if (in_fire) begin
          load_key_byte = 1'b1;
          if (byte_cnt == 4'd15) begin
            next_state = LOAD_PT;
          end
        end
      end
      LOAD_PT: begin
        if (in_fire) begin
          load_pt_byte = 1'b1;
          if (byte_cnt == 4'd15) begin
            next_state = RUN;
          end
        end
      end
      RUN: begin
        eng_start = 1'b1;
        // A result arriving on the watchdog's last cycle is still taken
        if (eng_ok) begin
          next_state = DRAIN;
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && byte_cnt == 4'd15) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 4'd0;
      wdog      <= 16'd0;
      shift     <= 128'd0;
      eng_key   <= 128'd0;
      eng_plain <= 128'd0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (next_state == IDLE) begin
        byte_cnt <= 4'd0;
      end else if (load_key_byte || load_pt_byte || out_fire) begin
        byte_cnt <= byte_cnt + 4'd1;
      end

      if (load_key_byte) begin
        eng_key[byte_msb -: 8] <= in_data;
      end
      if (load_pt_byte) begin
        eng_plain[byte_msb -: 8] <= in_data;
      end

      if (state == RUN) begin
        wdog <= wdog + 16'd1;
      end else begin
        wdog <= 16'd0;
      end

      if (state == RUN && eng_ok) begin
        shift <= eng_cipher;
      end else if (out_fire) begin
        shift <= {shift[119:0], 8'h00};
      end

      if (state == RUN && !eng_ok && timeout_hit) begin
        err <= 1'b1;
      end else if (in_fire) begin
        err <= 1'b0;
      end

      // Registered so ready never depends on valid and stays low through reset
      in_ready <= (next_state == IDLE) || (next_state == LOAD_KEY) || (next_state == LOAD_PT);
    end
  end

endmodule

// File: tb/tb_aes_byte_if.sv
// Self-checking bench for aes_byte_if: engine stub plus a byte-level reference model
// covering reset, FIPS-197 vector, key reuse, backpressure, watchdog and reset mid-run.
module tb_aes_byte_if;

  localparam int unsigned TIMEOUT = 20;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef logic [7:0] byte16_t [16];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_keep_key = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic [127:0] eng_plain;
  logic [127:0] eng_key;
  logic         eng_start;
  logic [127:0] eng_cipher;
  logic         eng_ok = 1'b0;
  logic         busy;
  logic         err;

  int           n_checks = 0;
  int           n_pass = 0;
  logic         stub_hang = 1'b0;
  int           stub_lat = 3;
  int           stub_cnt = 0;
  logic [127:0] model_key = 128'd0;

  aes_byte_if #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_keep_key (in_keep_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .eng_plain   (eng_plain),
    .eng_key     (eng_key),
    .eng_start   (eng_start),
    .eng_cipher  (eng_cipher),
    .eng_ok      (eng_ok),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Stand-in engine: knows the FIPS-197 vector, otherwise a keyed scramble
  function automatic logic [127:0] engine_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  assign eng_cipher = engine_fn(eng_key, eng_plain);

  always @(posedge clk) begin
    if (!eng_start) begin
      stub_cnt <= 0;
      eng_ok   <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!stub_hang && stub_cnt == stub_lat) eng_ok <= 1'b1;
    end
  end

  function automatic logic [127:0] pack_bytes(input byte16_t b);
    logic [127:0] v = 128'd0;
    for (int i = 0; i < 16; i++) v = {v[119:0], b[i]};
    return v;
  endfunction

  function automatic byte16_t unpack_bytes(input logic [127:0] v);
    byte16_t b;
    for (int i = 0; i < 16; i++) b[i] = v[127 - 8 * i -: 8];
    return b;
  endfunction

  function automatic byte16_t rand_bytes();
    byte16_t b;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic keep, input byte16_t kb, input byte16_t pb);
    int total = keep ? 16 : 32;
    int stalls = 0;
    int waited;
    for (int i = 0; i < total; i++) begin
      in_valid    = 1'b1;
      in_data     = keep ? pb[i] : (i < 16 ? kb[i] : pb[i - 16]);
      in_keep_key = (i == 0) ? keep : ~keep;
      waited = 0;
      while (!in_ready && waited < 50) begin
        step();
        waited++;
      end
      if (!in_ready) begin
        check("in_ready_wait", 128'd0, 128'd1);
        in_valid = 1'b0;
        return;
      end
      if (i > 0 && waited > 0) stalls++;
      step();
      if (i == 0) check("err_clear_on_accept", 128'(err), 128'd0);
    end
    in_valid    = 1'b0;
    in_keep_key = 1'b0;
    if (!keep) model_key = pack_bytes(kb);
    check("load_stalls", 128'(stalls), 128'd0);
    check("start_after_last_byte", 128'(eng_start), 128'd1);
    check("ready_low_in_run", 128'(in_ready), 128'd0);
    check("eng_key", eng_key, model_key);
    check("eng_plain", eng_plain, pack_bytes(pb));
  endtask

  task automatic checkOutput(input byte16_t exp, input logic bp);
    int waited = 0;
    int got = 0;
    int cycles = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    out_ready = 1'b0;
    while (!eng_ok && waited < 60) begin
      step();
      waited++;
    end
    if (!eng_ok) begin
      check("eng_ok_wait", 128'd0, 128'd1);
      return;
    end
    step();
    check("ok_to_valid", 128'(out_valid), 128'd1);
    while (got < 16 && cycles < 300) begin
      if (stalled) check("stall_hold", 128'({out_valid, out_data}), 128'({1'b1, held}));
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        check($sformatf("out_byte%0d", got), 128'(out_data), 128'(exp[got]));
        got++;
      end
      step();
      cycles++;
    end
    out_ready = 1'b0;
    check("drain_count", 128'(got), 128'd16);
    if (!bp) check("drain_cycles", 128'(cycles), 128'd16);
    check("valid_low_after", 128'(out_valid), 128'd0);
    check("idle_after_drain", 128'(busy), 128'd0);
  endtask

  initial begin
    byte16_t kb;
    byte16_t pb;
    byte16_t fips_ct;
    int k;
    logic saw_valid;

    fips_ct = unpack_bytes(FIPS_CT);

    $display("[TB] reset with in_valid high");
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hab;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_ctrl", 128'({in_ready, out_valid, out_data, eng_start, busy, err}), 128'd0);
      check("rst_key_plain", {eng_key ^ eng_plain}, 128'd0);
    end
    check("rst_key", eng_key, 128'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    model_key = 128'd0;
    step();
    check("ready_after_rst", 128'({in_ready, busy}), 128'b10);
    check("no_byte_accepted", eng_key, 128'd0);

    $display("[TB] FIPS-197 vector");
    stub_lat = 4;
    applyStimulus(1'b0, unpack_bytes(FIPS_KEY), unpack_bytes(FIPS_PT));
    checkOutput(fips_ct, 1'b0);

    $display("[TB] key reuse");
    step();
    applyStimulus(1'b1, kb, unpack_bytes(FIPS_PT));
    checkOutput(fips_ct, 1'b0);

    $display("[TB] random jobs with backpressure");
    for (int j = 0; j < 4; j++) begin
      kb = rand_bytes();
      pb = rand_bytes();
      stub_lat = int'($urandom_range(0, 15));
      applyStimulus(1'(j % 2), kb, pb);
      checkOutput(unpack_bytes(engine_fn(model_key, pack_bytes(pb))), 1'b1);
    end

    $display("[TB] watchdog timeout");
    stub_hang = 1'b1;
    kb = rand_bytes();
    pb = rand_bytes();
    applyStimulus(1'b0, kb, pb);
    k = 0;
    saw_valid = 1'b0;
    while (eng_start && k < 100) begin
      step();
      k++;
      if (out_valid) saw_valid = 1'b1;
    end
    check("timeout_cycles", 128'(k), 128'(TIMEOUT));
    check("err_set", 128'(err), 128'd1);
    check("no_out_valid", 128'(saw_valid), 128'd0);
    check("idle_after_timeout", 128'(busy), 128'd0);
    repeat (3) step();
    check("err_sticky", 128'(err), 128'd1);
    stub_hang = 1'b0;
    pb = rand_bytes();
    applyStimulus(1'b1, kb, pb);
    checkOutput(unpack_bytes(engine_fn(model_key, pack_bytes(pb))), 1'b0);

    $display("[TB] reset during RUN");
    stub_hang = 1'b1;
    applyStimulus(1'b0, unpack_bytes(FIPS_KEY), unpack_bytes(FIPS_PT));
    repeat (5) step();
    rst = 1'b1;
    step();
    check("start_dropped_by_rst", 128'({eng_start, busy, in_ready}), 128'd0);
    check("key_cleared_by_rst", eng_key, 128'd0);
    rst = 1'b0;
    model_key = 128'd0;
    stub_hang = 1'b0;
    step();
    applyStimulus(1'b0, unpack_bytes(FIPS_KEY), unpack_bytes(FIPS_PT));
    checkOutput(fips_ct, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "[TB] global timeout");
  end

endmodule
